// File: rtl/dvb_pls_dec_rm_fht.sv
// RM(1,pM) soft-decision decoder: serial Hadamard correlation, then a shifted sort for best/second-best row.
// Optional build macro DVB_PLS_DEC_RM_FHT_MARGIN_EN enables second-best tracking and omargin.

module dvb_pls_dec_rm_fht_lane #(
  parameter  int pM     = 5,
  parameter  int pDAT_W = 4,
  parameter  int W      = 0,
  localparam int pSUM_W = pDAT_W + pM
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              iclkena,
  input  logic              iload,
  input  logic              iadd,
  input  logic              ishift,
  input  logic [pM-1:0]     ik,
  input  logic [pDAT_W-1:0] idat,
  input  logic [pSUM_W-1:0] ishift_in,
  output logic [pSUM_W-1:0] oacc
);
  localparam logic [pM-1:0] ROW = pM'(W);

  logic [pSUM_W-1:0] dext, term, acc_d, acc_q;

  always_comb begin
    dext  = {{pM{idat[pDAT_W-1]}}, idat};
    term  = (^(ROW & ik)) ? (~dext + pSUM_W'(1)) : dext;
    acc_d = acc_q;
    if (iload)       acc_d = term;
    else if (iadd)   acc_d = acc_q + term;
    else if (ishift) acc_d = ishift_in;
  end

  always_ff @(posedge iclk or negedge ireset_n)
    if (!ireset_n)    acc_q <= '0;
    else if (iclkena) acc_q <= acc_d;

  assign oacc = acc_q;
endmodule

module dvb_pls_dec_rm_fht #(
  parameter  int pM     = 5,
  parameter  int pDAT_W = 4,
  localparam int pSUM_W = pDAT_W + pM
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              iclkena,
  input  logic              isop,
  input  logic              ival,
  input  logic              ieop,
  input  logic [pDAT_W-1:0] idat,
  output logic              ordy,
  output logic              oerr,
  output logic              oval,
  output logic [pM:0]       odat,
  output logic [pSUM_W-1:0] ometric,
  output logic [pSUM_W-1:0] omargin
);
  localparam int N = 1 << pM;
  localparam logic [pM-1:0] K_LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_SORT, S_FLUSH, S_OUT} state_t;

  state_t state_q, state_d;
  logic [pM-1:0] cnt_q, cnt_d;
  logic acc_in, lane_load, lane_add, lane_shift, clear_best;
  logic [pM-1:0] lane_k;
  logic [N-1:0][pSUM_W-1:0] acc, shin;

  logic              vld_q, vld_d, sgn_q, sgn_d, bsgn_q, bsgn_d;
  logic [pSUM_W-1:0] abs_q, abs_d, best_q, best_d;
  logic [pM-1:0]     idx_q, idx_d, bidx_q, bidx_d;
`ifdef DVB_PLS_DEC_RM_FHT_MARGIN_EN
  logic [pSUM_W-1:0] sec_q, sec_d;
`endif

  logic              oerr_q, oerr_d, oval_q, oval_d;
  logic [pM:0]       odat_q, odat_d;
  logic [pSUM_W-1:0] omet_q, omet_d, omar_q, omar_d;

  assign ordy   = (state_q == S_IDLE) || (state_q == S_ACC);
  assign acc_in = ival & ordy;
  assign lane_k = lane_load ? '0 : cnt_q;
  // During SORT every lane takes its upper neighbour, so row w reaches lane 0 on sort cycle w.
  assign shin   = {{pSUM_W{1'b0}}, acc[N-1:1]};

  for (genvar w = 0; w < N; w++) begin : g_lane
    dvb_pls_dec_rm_fht_lane #(.pM(pM), .pDAT_W(pDAT_W), .W(w)) u_lane (
      .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena),
      .iload(lane_load), .iadd(lane_add), .ishift(lane_shift),
      .ik(lane_k), .idat(idat), .ishift_in(shin[w]), .oacc(acc[w])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    oerr_d     = 1'b0;
    lane_load  = 1'b0;
    lane_add   = 1'b0;
    lane_shift = 1'b0;
    clear_best = 1'b0;
    case (state_q)
      S_IDLE: if (acc_in && isop) begin
        lane_load = 1'b1;
        cnt_d     = pM'(1);
        state_d   = S_ACC;
      end
      S_ACC: if (acc_in) begin
        if (isop) begin
          lane_load = 1'b1;
          cnt_d     = pM'(1);
        end else begin
          lane_add = 1'b1;
          if (ieop && cnt_q == K_LAST) begin
            state_d    = S_SORT;
            cnt_d      = '0;
            clear_best = 1'b1;
          end else if (ieop || cnt_q == K_LAST) begin
            oerr_d  = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + pM'(1);
          end
        end
      end
      S_SORT: begin
        lane_shift = 1'b1;
        cnt_d      = cnt_q + pM'(1);
        if (cnt_q == K_LAST) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + pM'(1);
        if (cnt_q == pM'(1)) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 1 registers |sum| and sign of lane 0; stage 2 keeps the running best/second best.
  always_comb begin
    vld_d  = (state_q == S_SORT);
    idx_d  = cnt_q;
    sgn_d  = acc[0][pSUM_W-1];
    abs_d  = sgn_d ? (~acc[0] + pSUM_W'(1)) : acc[0];
    best_d = best_q;
    bidx_d = bidx_q;
    bsgn_d = bsgn_q;
`ifdef DVB_PLS_DEC_RM_FHT_MARGIN_EN
    sec_d  = sec_q;
`endif
    if (clear_best) begin
      best_d = '0;
      bidx_d = '0;
      bsgn_d = 1'b0;
`ifdef DVB_PLS_DEC_RM_FHT_MARGIN_EN
      sec_d  = '0;
`endif
    end else if (vld_q) begin
      if (abs_q > best_q) begin
`ifdef DVB_PLS_DEC_RM_FHT_MARGIN_EN
        sec_d  = best_q;
`endif
        best_d = abs_q;
        bidx_d = idx_q;
        bsgn_d = sgn_q;
      end
`ifdef DVB_PLS_DEC_RM_FHT_MARGIN_EN
      else if (abs_q > sec_q) sec_d = abs_q;
`endif
    end
  end

  always_comb begin
    oval_d = (state_q == S_OUT);
    odat_d = odat_q;
    omet_d = omet_q;
    omar_d = omar_q;
    if (oval_d) begin
      odat_d = {bidx_q, bsgn_q};
      omet_d = best_q;
`ifdef DVB_PLS_DEC_RM_FHT_MARGIN_EN
      omar_d = best_q - sec_q;
`else
      omar_d = '0;
`endif
    end
  end

  always_ff @(posedge iclk or negedge ireset_n)
    if (!ireset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      abs_q   <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      best_q  <= '0;
      bidx_q  <= '0;
      bsgn_q  <= 1'b0;
`ifdef DVB_PLS_DEC_RM_FHT_MARGIN_EN
      sec_q   <= '0;
`endif
      oerr_q  <= 1'b0;
      oval_q  <= 1'b0;
      odat_q  <= '0;
      omet_q  <= '0;
      omar_q  <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      abs_q   <= abs_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      bidx_q  <= bidx_d;
      bsgn_q  <= bsgn_d;
`ifdef DVB_PLS_DEC_RM_FHT_MARGIN_EN
      sec_q   <= sec_d;
`endif
      oerr_q  <= oerr_d;
      oval_q  <= oval_d;
      odat_q  <= odat_d;
      omet_q  <= omet_d;
      omar_q  <= omar_d;
    end

  assign oerr    = oerr_q;
  assign oval    = oval_q;
  assign odat    = odat_q;
  assign ometric = omet_q;
  assign omargin = omar_q;
endmodule

// File: tb/tb_dvb_pls_dec_rm_fht.sv
// Directed bench for dvb_pls_dec_rm_fht (pM=5, pDAT_W=4); margin expectations follow DVB_PLS_DEC_RM_FHT_MARGIN_EN.
module tb_dvb_pls_dec_rm_fht;
  localparam int N = 32;

  logic       clk = 1'b0;
  logic       ireset_n, iclkena, isop, ival, ieop;
  logic [3:0] idat;
  logic       ordy, oerr, oval;
  logic [5:0] odat;
  logic [8:0] ometric, omargin;

  int n_assert = 0;
  int n_fail   = 0;
  int fr[N];

  always #5 clk = ~clk;

  dvb_pls_dec_rm_fht dut (
    .iclk(clk), .ireset_n(ireset_n), .iclkena(iclkena),
    .isop(isop), .ival(ival), .ieop(ieop), .idat(idat),
    .ordy(ordy), .oerr(oerr), .oval(oval), .odat(odat),
    .ometric(ometric), .omargin(omargin)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int em(input int m);
`ifdef DVB_PLS_DEC_RM_FHT_MARGIN_EN
    return m;
`else
    return 0;
`endif
  endfunction

  // Codeword c_k = s ^ parity(w&k), bit 0 -> +amp, bit 1 -> -amp.
  task automatic set_cw(input int w, input int s, input int amp);
    for (int k = 0; k < N; k++) begin
      logic [4:0] wk;
      wk = 5'(w) & 5'(k);
      fr[k] = ((s ^ int'(^wk)) != 0) ? -amp : amp;
    end
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < N; k++) fr[k] = v;
  endtask

  // Called at a negedge; returns at the negedge of cycle T+1.
  task automatic run_frame(input int last, input bit eop, input int gap_at);
    for (int k = 0; k <= last; k++) begin
      if (k == gap_at) begin
        ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        @(negedge clk);
      end
      isop = (k == 0);
      ival = 1'b1;
      ieop = eop && (k == last);
      idat = 4'(fr[k]);
      @(negedge clk);
    end
    isop = 1'b0; ival = 1'b0; ieop = 1'b0;
  endtask

  // Starts at the negedge of cycle T+1, ends at the negedge of cycle T+N+4.
  task automatic wait_result(input string tag, input int e_dat, input int e_met, input int e_mar, input bit junk);
    int bad;
    bad = 0;
    for (int i = 1; i <= N + 4; i++) begin
      if (i > 1) @(negedge clk);
      if (i < N + 4) begin
        if (ordy !== 1'b0 || oval !== 1'b0) bad++;
        if (junk) begin
          ival = 1'b1;
          idat = 4'($urandom);
        end
      end
    end
    ival = 1'b0;
    chk({tag, " busy window ordy/oval low"}, bad, 0);
    chk({tag, " oval"}, oval, 1);
    chk({tag, " ordy"}, ordy, 1);
    chk({tag, " odat"}, odat, e_dat);
    chk({tag, " ometric"}, ometric, e_met);
    chk({tag, " omargin"}, omargin, em(e_mar));
  endtask

  task automatic no_oval(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (oval !== 1'b0) seen++;
    end
    chk({tag, " no oval"}, seen, 0);
  endtask

  initial begin
    ireset_n = 1'b0; iclkena = 1'b1;
    isop = 1'b0; ival = 1'b0; ieop = 1'b0; idat = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset ordy", ordy, 1);
    chk("reset oval", oval, 0);
    chk("reset oerr", oerr, 0);
    chk("reset odat", odat, 0);
    chk("reset ometric", ometric, 0);
    chk("reset omargin", omargin, 0);
    ireset_n = 1'b1;
    @(negedge clk);

    // Stray ival in IDLE without isop must be ignored.
    ival = 1'b1; idat = 4'd5;
    @(negedge clk);
    ival = 1'b0;
    chk("idle stray ival oerr", oerr, 0);

    set_all(7);
    run_frame(N - 1, 1'b1, -1);
    wait_result("all+7", 6'h00, 224, 224, 1'b0);
    @(negedge clk);
    chk("all+7 oval pulse", oval, 0);
    chk("all+7 odat hold", odat, 6'h00);

    set_cw(5, 1, 7);
    run_frame(N - 1, 1'b1, -1);
    wait_result("cw5s1", 6'h0B, 224, 224, 1'b0);

    // Three flipped samples k=1,2,4: rows 13/21/29 reach +42, row 5 drops to -182.
    set_cw(5, 1, 7);
    fr[1] = -fr[1]; fr[2] = -fr[2]; fr[4] = -fr[4];
    run_frame(N - 1, 1'b1, 16);
    wait_result("cw5 3flip gap", 6'h0B, 182, 140, 1'b0);

    set_all(0);
    run_frame(N - 1, 1'b1, -1);
    wait_result("zero", 6'h00, 0, 0, 1'b0);

    set_all(-8);
    run_frame(N - 1, 1'b1, -1);
    wait_result("all-8", 6'h01, 256, 256, 1'b0);

    // Early ieop on sample 20.
    set_cw(5, 1, 7);
    run_frame(20, 1'b1, -1);
    chk("early eop oerr", oerr, 1);
    chk("early eop ordy", ordy, 1);
    @(negedge clk);
    chk("early eop oerr pulse", oerr, 0);
    no_oval("early eop", N + 6);
    run_frame(N - 1, 1'b1, -1);
    wait_result("after err", 6'h0B, 224, 224, 1'b0);

    // Sample N-1 without ieop.
    run_frame(N - 1, 1'b0, -1);
    chk("missing eop oerr", oerr, 1);
    no_oval("missing eop", N + 6);

    // Mid-frame isop restarts the frame silently.
    set_all(-8);
    run_frame(9, 1'b0, -1);
    chk("restart partial no oerr", oerr, 0);
    set_cw(9, 0, 6);
    run_frame(N - 1, 1'b1, -1);
    chk("restart no oerr", oerr, 0);
    wait_result("restart cw9s0", 6'h12, 192, 192, 1'b0);

    // Random samples offered while busy must be dropped.
    set_cw(5, 1, 7);
    fr[1] = -fr[1]; fr[2] = -fr[2]; fr[4] = -fr[4];
    run_frame(N - 1, 1'b1, -1);
    wait_result("junk while busy", 6'h0B, 182, 140, 1'b1);

    // Back-to-back at minimum period.
    set_cw(5, 1, 7);
    run_frame(N - 1, 1'b1, -1);
    wait_result("b2b first", 6'h0B, 224, 224, 1'b0);
    set_all(7);
    run_frame(N - 1, 1'b1, -1);
    wait_result("b2b second", 6'h00, 224, 224, 1'b0);

    // Reset pulse during SORT.
    set_cw(5, 1, 7);
    run_frame(N - 1, 1'b1, -1);
    repeat (4) @(negedge clk);
    ireset_n = 1'b0;
    @(negedge clk);
    chk("sort reset ordy", ordy, 1);
    chk("sort reset oval", oval, 0);
    chk("sort reset odat", odat, 0);
    chk("sort reset ometric", ometric, 0);
    chk("sort reset omargin", omargin, 0);
    ireset_n = 1'b1;
    no_oval("sort reset", N + 6);
    chk("sort reset oerr", oerr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
